// File: rtl/sb_arbiter_rr.sv
// rtl/sb_arbiter_rr.sv - N-master round-robin system-bus arbiter with lock limit and SPLIT masking
module sb_arbiter_rr #(
  parameter int NUM_MASTERS = 4,
  parameter int LOCK_MAX    = 8,
  localparam int MIDX_W     = $clog2(NUM_MASTERS + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [NUM_MASTERS-1:0] lock,
  input  logic                   xfer_done,
  input  logic [1:0]             resp,
  input  logic [NUM_MASTERS-1:0] split_clr,
  output logic [NUM_MASTERS-1:0] gnt,
  output logic [MIDX_W-1:0]      sb_masters,
  output logic                   sb_mastlock,
  output logic [NUM_MASTERS-1:0] split_mask,
  output logic                   lock_timeout
);

  localparam int IDX_W = $clog2(NUM_MASTERS);
  localparam int CNT_W = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;
  localparam logic [1:0] RESP_RETRY = 2'b10;
  localparam logic [1:0] RESP_SPLIT = 2'b11;

  typedef enum logic {ST_IDLE, ST_OWNED} state_e;

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       ptr_q, ptr_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [NUM_MASTERS-1:0] mask_q, mask_d;
  logic [NUM_MASTERS-1:0] gnt_q, gnt_d;
  logic [MIDX_W-1:0]      masters_q, masters_d;
  logic                   mastlock_q, mastlock_d;
  logic                   tout_q, tout_d;

  logic [NUM_MASTERS-1:0] eligible;
  logic [NUM_MASTERS-1:0] owner_oh;
  logic [NUM_MASTERS-1:0] arb_cand;
  logic                   arb_req;
  logic                   keep_on_empty;
  logic                   timeout_hit;
  logic                   limit_hit;
  logic                   arb_found;
  logic [IDX_W-1:0]       arb_idx;

  // First set bit of cand searching upward from base+1 with wrap-around; MSB is the found flag.
  function automatic logic [IDX_W:0] rr_pick(input logic [NUM_MASTERS-1:0] cand,
                                             input logic [IDX_W-1:0]       base);
    logic             found;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] jj;
    int               j;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      j = int'(base) + 1 + i;
      if (j >= NUM_MASTERS) j = j - NUM_MASTERS;
      jj = IDX_W'(j);
      if (!found && cand[jj]) begin
        found = 1'b1;
        idx   = jj;
      end
    end
    return {found, idx};
  endfunction

  // ptr_q always equals the current owner while OWNED, so it doubles as the owner index.
  assign eligible  = req & ~mask_q;
  assign owner_oh  = NUM_MASTERS'(1) << ptr_q;
  assign limit_hit = (LOCK_MAX != 0) && ((int'(cnt_q) + 1) >= LOCK_MAX);

  // Next-state decision: release/keep rules for the owner, then one round-robin search.
  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    cnt_d         = cnt_q;
    mask_d        = mask_q & ~split_clr;
    tout_d        = 1'b0;
    mastlock_d    = 1'b0;
    arb_req       = 1'b0;
    arb_cand      = '0;
    keep_on_empty = 1'b0;
    timeout_hit   = 1'b0;
    arb_found     = 1'b0;
    arb_idx       = '0;

    case (state_q)
      ST_IDLE: begin
        arb_req  = |eligible;
        arb_cand = eligible;
      end
      ST_OWNED: begin
        mastlock_d = lock[ptr_q];
        if (!req[ptr_q]) begin
          arb_req  = 1'b1;
          arb_cand = eligible & ~owner_oh;
          cnt_d    = '0;
        end else if (xfer_done && (resp == RESP_SPLIT)) begin
          mask_d[ptr_q] = 1'b1;
          arb_req       = 1'b1;
          arb_cand      = eligible & ~owner_oh;
          cnt_d         = '0;
        end else if (xfer_done && (resp == RESP_RETRY)) begin
          cnt_d = cnt_q;
        end else if (xfer_done) begin
          if (lock[ptr_q] && !limit_hit) begin
            cnt_d = cnt_q + CNT_W'(1);
          end else if (lock[ptr_q]) begin
            tout_d        = 1'b1;
            cnt_d         = '0;
            arb_req       = 1'b1;
            arb_cand      = eligible & ~owner_oh;
            keep_on_empty = 1'b1;
            timeout_hit   = 1'b1;
          end else begin
            cnt_d    = '0;
            arb_req  = 1'b1;
            arb_cand = eligible;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (arb_req) begin
      {arb_found, arb_idx} = rr_pick(arb_cand, ptr_q);
      if (arb_found) begin
        state_d    = ST_OWNED;
        ptr_d      = arb_idx;
        mastlock_d = timeout_hit ? 1'b0 : lock[arb_idx];
      end else if (!keep_on_empty) begin
        state_d    = ST_IDLE;
        mastlock_d = 1'b0;
      end
    end

    gnt_d     = (state_d == ST_OWNED) ? (NUM_MASTERS'(1) << ptr_d) : '0;
    masters_d = (state_d == ST_OWNED) ? (MIDX_W'(ptr_d) + MIDX_W'(1)) : '0;
  end

  // State, pointer, lock counter, split mask and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      cnt_q      <= '0;
      mask_q     <= '0;
      gnt_q      <= '0;
      masters_q  <= '0;
      mastlock_q <= 1'b0;
      tout_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      mask_q     <= mask_d;
      gnt_q      <= gnt_d;
      masters_q  <= masters_d;
      mastlock_q <= mastlock_d;
      tout_q     <= tout_d;
    end
  end

  assign gnt          = gnt_q;
  assign sb_masters   = masters_q;
  assign sb_mastlock  = mastlock_q;
  assign split_mask   = mask_q;
  assign lock_timeout = tout_q;

endmodule
